// File: rtl/trial_pkg.sv
// Shared types for the trial/retry responder: lock state encoding and the
// registered response record.
package trial_pkg;

  localparam int unsigned MaxIdWidth = 32;

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  // The ID field is sized for the widest supported requester ID.
  typedef struct packed {
    logic                  ack;
    logic [MaxIdWidth-1:0] id;
  } rsp_t;

endpackage

// File: rtl/lease_timer.sv
// Lock lease down-counter: loaded on grant, counts down while locked, and
// flags expiry on the cycle it sits at zero. LeaseCycles == 0 never expires.
module lease_timer #(
  parameter int unsigned CntWidth    = 16,
  parameter int unsigned LeaseCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic clr_i,
  input  logic run_i,
  output logic expire_o
);

  localparam logic [CntWidth-1:0] LoadVal =
    (LeaseCycles == 0) ? '0 : CntWidth'(LeaseCycles - 1);
  localparam logic Enabled = (LeaseCycles != 0);

  logic [CntWidth-1:0] r_cnt;
  logic                w_zero;

  assign w_zero   = (r_cnt == '0);
  assign expire_o = Enabled && run_i && w_zero;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= LoadVal;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (run_i && !w_zero) begin
      r_cnt <= r_cnt - CntWidth'(1);
    end
  end

endmodule

// File: rtl/trial_responder.sv
// Responder side of the trial/retry lock protocol (ACK grants/refreshes the
// lock, NACK tells the requester to back off). TRIAL_RESPONDER_STATS_EN adds a NACK counter.
module trial_responder
  import trial_pkg::*;
#(
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned LeaseCycles = 1024,
  parameter int unsigned CntWidth    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [IdWidth-1:0]  req_id_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_ack_o,
  output logic [IdWidth-1:0]  rsp_id_o,
  input  logic                rel_valid_i,
  input  logic [IdWidth-1:0]  rel_id_i,
  output logic                locked_o,
  output logic [IdWidth-1:0]  owner_o,
  output logic                timeout_o,
  output logic [CntWidth-1:0] nack_cnt_o
);

`ifndef COMMON_CELLS_ASSERTS_OFF
  if (IdWidth == 0) begin : g_chk_id_min
    $error("trial_responder: IdWidth must be >= 1");
  end
  if (IdWidth > MaxIdWidth) begin : g_chk_id_max
    $error("trial_responder: IdWidth exceeds trial_pkg::MaxIdWidth");
  end
  if (CntWidth < 64 && 64'(LeaseCycles) > (64'd1 << CntWidth)) begin : g_chk_lease
    $error("trial_responder: LeaseCycles must not exceed 2**CntWidth");
  end
`endif

  lock_state_e        r_state, w_state_nxt;
  logic [IdWidth-1:0] r_owner, w_owner_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic               r_rsp_valid;
  rsp_t               r_rsp;

  logic w_locked, w_req_ready, w_accept;
  logic w_rel_ok, w_expire, w_free_eff, w_owner_hit;
  logic w_ack, w_grant, w_refresh, w_clr;
  logic [MaxIdWidth-1:0] w_unused_rsp_id;

  assign w_locked    = (r_state == ST_LOCKED);
  assign w_req_ready = !r_rsp_valid || rsp_ready_i;
  assign w_accept    = req_valid_i && w_req_ready;

  // Release/expiry resolve before the request, so a waiting ID can win this cycle.
  assign w_rel_ok    = w_locked && rel_valid_i && (rel_id_i == r_owner);
  assign w_free_eff  = !w_locked || w_rel_ok || w_expire;
  assign w_owner_hit = w_locked && (req_id_i == r_owner);
  assign w_ack       = w_free_eff || w_owner_hit;
  assign w_grant     = w_accept && w_ack;
  assign w_refresh   = w_grant && w_owner_hit;
  assign w_clr       = w_locked && !w_grant && (w_rel_ok || w_expire);

  lease_timer #(
    .CntWidth    (CntWidth),
    .LeaseCycles (LeaseCycles)
  ) u_lease_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (w_grant),
    .clr_i    (w_clr),
    .run_i    (w_locked),
    .expire_o (w_expire)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_timeout_nxt = w_expire && !w_rel_ok && !w_refresh;
    case (r_state)
      ST_FREE: begin
        if (w_grant) begin
          w_state_nxt = ST_LOCKED;
          w_owner_nxt = req_id_i;
        end
      end
      ST_LOCKED: begin
        if (w_grant) begin
          w_owner_nxt = req_id_i;
        end else if (w_rel_ok || w_expire) begin
          w_state_nxt = ST_FREE;
          w_owner_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_FREE;
        w_owner_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_FREE;
      r_owner   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp.ack   <= w_ack;
      r_rsp.id    <= MaxIdWidth'(req_id_i);
    end else if (rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Upper ID bits of the shared record are always zero here.
  assign w_unused_rsp_id = r_rsp.id;

`ifdef TRIAL_RESPONDER_STATS_EN
  logic [CntWidth-1:0] r_nack_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_nack_cnt <= '0;
    end else if (w_accept && !w_ack && (r_nack_cnt != '1)) begin
      r_nack_cnt <= r_nack_cnt + CntWidth'(1);
    end
  end

  assign nack_cnt_o = r_nack_cnt;
`else
  assign nack_cnt_o = '0;
`endif

  assign req_ready_o = w_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_ack_o   = r_rsp.ack;
  assign rsp_id_o    = r_rsp.id[IdWidth-1:0];
  assign locked_o    = w_locked;
  assign owner_o     = r_owner;
  assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_trial_responder.sv
// Self-checking bench for trial_responder: vector table plus hand-written
// lease, back-pressure and reset sequences, responses checked via a scoreboard.
module tb_trial_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, rsp_ready, rel_valid;
  logic [3:0] req_id, rel_id;

  logic        req_ready, rsp_valid, rsp_ack, locked, timeout;
  logic [3:0]  rsp_id, owner;
  logic [15:0] nack_cnt;

  logic       d4_req_ready, d4_rsp_valid, d4_rsp_ack, d4_locked, d4_timeout;
  logic [3:0] d4_rsp_id, d4_owner;
  logic [7:0] d4_nack_cnt;

  always #5 clk = ~clk;

  trial_responder #(
    .IdWidth     (4),
    .LeaseCycles (1024),
    .CntWidth    (16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_id_i    (req_id),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_ack_o   (rsp_ack),
    .rsp_id_o    (rsp_id),
    .rel_valid_i (rel_valid),
    .rel_id_i    (rel_id),
    .locked_o    (locked),
    .owner_o     (owner),
    .timeout_o   (timeout),
    .nack_cnt_o  (nack_cnt)
  );

  trial_responder #(
    .IdWidth     (4),
    .LeaseCycles (4),
    .CntWidth    (8)
  ) dut4 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (d4_req_ready),
    .req_id_i    (req_id),
    .rsp_valid_o (d4_rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_ack_o   (d4_rsp_ack),
    .rsp_id_o    (d4_rsp_id),
    .rel_valid_i (rel_valid),
    .rel_id_i    (rel_id),
    .locked_o    (d4_locked),
    .owner_o     (d4_owner),
    .timeout_o   (d4_timeout),
    .nack_cnt_o  (d4_nack_cnt)
  );

  typedef struct packed {
    logic       ack;
    logic [3:0] id;
  } exp_rsp_t;

  typedef struct {
    logic       rv;
    logic [3:0] rid;
    logic       lv;
    logic [3:0] lid;
    logic       ack;
    logic       locked;
    logic [3:0] owner;
  } vec_t;

  exp_rsp_t sb_q[$];
  exp_rsp_t mon_e;
  int total = 0;
  int bad = 0;
  int exp_nack = 0;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int nack_model();
`ifdef TRIAL_RESPONDER_STATS_EN
    return exp_nack;
`else
    return 0;
`endif
  endfunction

  // Responses are consumed at the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got ack=%0b id=%0h expected none", rsp_ack, rsp_id);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_ack", {31'd0, rsp_ack}, {31'd0, mon_e.ack});
        check("rsp_id", {28'd0, rsp_id}, {28'd0, mon_e.id});
      end
    end
  end

  task automatic step(input logic rv, input logic [3:0] rid, input logic lv,
                      input logic [3:0] lid, input logic exp_ack);
    req_valid = rv;
    req_id    = rid;
    rel_valid = lv;
    rel_id    = lid;
    if (rv) begin
      sb_q.push_back('{ack: exp_ack, id: rid});
      if (!exp_ack) exp_nack++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rel_valid = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_locked"}, {31'd0, locked}, 32'd0);
    check({tag, "_owner"}, {28'd0, owner}, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_ack"}, {31'd0, rsp_ack}, 32'd0);
    check({tag, "_rsp_id"}, {28'd0, rsp_id}, 32'd0);
    check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    check({tag, "_nack"}, {16'd0, nack_cnt}, 32'd0);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_d4_locked"}, {31'd0, d4_locked}, 32'd0);
    check({tag, "_d4_timeout"}, {31'd0, d4_timeout}, 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    sb_q.delete();
    exp_nack = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{rv: 1, rid: 3, lv: 0, lid: 0, ack: 1, locked: 1, owner: 3};
    vecs[1]  = '{rv: 1, rid: 5, lv: 0, lid: 0, ack: 0, locked: 1, owner: 3};
    vecs[2]  = '{rv: 0, rid: 0, lv: 1, lid: 7, ack: 0, locked: 1, owner: 3};
    vecs[3]  = '{rv: 1, rid: 5, lv: 1, lid: 3, ack: 1, locked: 1, owner: 5};
    vecs[4]  = '{rv: 1, rid: 5, lv: 0, lid: 0, ack: 1, locked: 1, owner: 5};
    vecs[5]  = '{rv: 0, rid: 0, lv: 1, lid: 5, ack: 0, locked: 0, owner: 0};
    vecs[6]  = '{rv: 0, rid: 0, lv: 1, lid: 2, ack: 0, locked: 0, owner: 0};
    vecs[7]  = '{rv: 1, rid: 1, lv: 0, lid: 0, ack: 1, locked: 1, owner: 1};
    vecs[8]  = '{rv: 0, rid: 0, lv: 0, lid: 0, ack: 0, locked: 1, owner: 1};
    vecs[9]  = '{rv: 1, rid: 0, lv: 1, lid: 1, ack: 1, locked: 1, owner: 0};
    vecs[10] = '{rv: 0, rid: 0, lv: 1, lid: 0, ack: 0, locked: 0, owner: 0};

    req_valid = 1'b0; req_id = '0; rel_valid = 1'b0; rel_id = '0; rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].rv, vecs[i].rid, vecs[i].lv, vecs[i].lid, vecs[i].ack);
      check($sformatf("vec%0d_locked", i), {31'd0, locked}, {31'd0, vecs[i].locked});
      check($sformatf("vec%0d_owner", i), {28'd0, owner}, {28'd0, vecs[i].owner});
      check($sformatf("vec%0d_timeout", i), {31'd0, timeout}, 32'd0);
      check($sformatf("vec%0d_nack", i), {16'd0, nack_cnt}, nack_model());
    end
    idle();

    // Lease expiry on the 4-cycle instance.
    apply_reset();
    step(1'b1, 4'd2, 1'b0, 4'd0, 1'b1);
    check("lease_grant_locked", {31'd0, d4_locked}, 32'd1);
    check("lease_grant_owner", {28'd0, d4_owner}, 32'd2);
    for (int k = 1; k <= 3; k++) begin
      idle();
      check($sformatf("lease_c%0d_locked", k), {31'd0, d4_locked}, 32'd1);
      check($sformatf("lease_c%0d_timeout", k), {31'd0, d4_timeout}, 32'd0);
    end
    idle();
    check("lease_exp_locked", {31'd0, d4_locked}, 32'd0);
    check("lease_exp_owner", {28'd0, d4_owner}, 32'd0);
    check("lease_exp_timeout", {31'd0, d4_timeout}, 32'd1);
    idle();
    check("lease_pulse_end", {31'd0, d4_timeout}, 32'd0);
    check("lease_main_still_locked", {31'd0, locked}, 32'd1);
    step(1'b0, 4'd0, 1'b1, 4'd2, 1'b0);
    check("main_rel2", {31'd0, locked}, 32'd0);

    // Owner refresh in the expiry cycle suppresses the pulse.
    step(1'b1, 4'd6, 1'b0, 4'd0, 1'b1);
    repeat (3) idle();
    step(1'b1, 4'd6, 1'b0, 4'd0, 1'b1);
    check("refresh_locked", {31'd0, d4_locked}, 32'd1);
    check("refresh_owner", {28'd0, d4_owner}, 32'd6);
    check("refresh_timeout", {31'd0, d4_timeout}, 32'd0);
    repeat (3) idle();
    check("refresh_hold_locked", {31'd0, d4_locked}, 32'd1);
    // Valid release in the expiry cycle also suppresses it.
    step(1'b0, 4'd0, 1'b1, 4'd6, 1'b0);
    check("relexp_locked", {31'd0, d4_locked}, 32'd0);
    check("relexp_timeout", {31'd0, d4_timeout}, 32'd0);
    idle();
    check("relexp_timeout2", {31'd0, d4_timeout}, 32'd0);

    // Back-pressure on the response slot.
    rsp_ready = 1'b0;
    step(1'b1, 4'd4, 1'b0, 4'd0, 1'b1);
    check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("stall_req_ready", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b1;
    req_id    = 4'd9;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_valid", k), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("stall%0d_ack", k), {31'd0, rsp_ack}, 32'd1);
      check($sformatf("stall%0d_id", k), {28'd0, rsp_id}, 32'd4);
      check($sformatf("stall%0d_req_ready", k), {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    sb_q.push_back('{ack: 1'b0, id: 4'd9});
    exp_nack++;
    #1;
    check("unstall_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("unstall_rsp_ack", {31'd0, rsp_ack}, 32'd0);
    check("unstall_rsp_id", {28'd0, rsp_id}, 32'd9);
    check("unstall_nack", {16'd0, nack_cnt}, nack_model());
    idle();

    // Mismatched release, then reset while locked with a pending response.
    step(1'b0, 4'd0, 1'b1, 4'd7, 1'b0);
    check("rel7_locked", {31'd0, locked}, 32'd1);
    check("rel7_owner", {28'd0, owner}, 32'd4);
    rsp_ready = 1'b0;
    step(1'b1, 4'd4, 1'b0, 4'd0, 1'b1);
    check("pend_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #2;
    check_reset_vals("midreset");
    sb_q.delete();
    exp_nack = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) idle();
    check("post_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trial_responder.md
TRIAL_RESPONDER -- requirements
Module: trial_responder

Interface
REQ-001 SHALL have parameter IdWidth, default 4, requester ID width (>=1).
REQ-002 SHALL have parameter LeaseCycles, default 1024, lock lease length in cycles; 0 disables lease expiry.
REQ-003 SHALL have parameter CntWidth, default 16, width of the lease counter and NACK statistics counter.
REQ-004 SHALL have clk_i  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have req_valid_i  in  1 / req_ready_o  out  1 / req_id_i  in  IdWidth  trial request channel.
REQ-007 SHALL have rsp_valid_o  out  1 / rsp_ready_i  in  1 / rsp_ack_o  out  1 (1 = success, 0 = NACK) / rsp_id_o  out  IdWidth  response channel.
REQ-008 SHALL have rel_valid_i  in  1 / rel_id_i  in  IdWidth  lock release pulse.
REQ-009 SHALL have locked_o  out  1, owner_o  out  IdWidth, timeout_o  out  1 (expiry pulse), nack_cnt_o  out  CntWidth.

Function
REQ-010 SHALL implement the responder side of the retry protocol: ACK drives the requester's backoff clear, NACK drives its backoff set.
REQ-011 SHALL have states FREE and LOCKED; locked_o = (state == LOCKED); owner_o = current owner ID, 0 in FREE.
REQ-012 SHALL assert req_ready_o = !rsp_valid_o || rsp_ready_i (single registered response slot, full throughput).
REQ-013 SHALL decide on the accept cycle: ACK if effective state FREE or req_id_i == owner; otherwise NACK.
REQ-014 SHALL on ACK from FREE go to LOCKED with owner = req_id_i next cycle and load lease counter with LeaseCycles-1.
REQ-015 SHALL on ACK by current owner stay LOCKED and reload the lease counter (re-entrant refresh).
REQ-016 SHALL present the response one cycle after accept; rsp_ack_o/rsp_id_o held stable while rsp_valid_o && !rsp_ready_i.
REQ-017 SHALL on rel_valid_i with rel_id_i == owner in LOCKED go to FREE next cycle; mismatched ID or release in FREE SHALL be ignored.
REQ-018 SHALL, with LeaseCycles > 0, decrement the lease counter each LOCKED cycle and, on the cycle it is 0, go to FREE and pulse timeout_o for exactly one cycle.
REQ-019 SHALL resolve same-cycle events in order: valid release or lease expiry first, then the request; a request from another ID in that cycle SHALL be ACKed and take ownership.
REQ-020 SHALL suppress timeout_o when a valid release or owner refresh occurs in the expiry cycle.
REQ-021 SHALL keep lease counter width CntWidth; LeaseCycles > 2**CntWidth is a parameter error.

Reset
REQ-022 SHALL on reset set state FREE, owner_o 0, rsp_valid_o 0, rsp_ack_o 0, rsp_id_o 0, timeout_o 0, lease counter 0, nack_cnt_o 0, req_ready_o 1.
REQ-023 SHALL on reset mid-lock or with a pending response discard both; no response is produced after reset for pre-reset requests.

Configuration
REQ-024 SHALL with macro TRIAL_RESPONDER_STATS_EN defined increment nack_cnt_o on every NACK accept, saturating at all-ones.
REQ-025 SHALL without TRIAL_RESPONDER_STATS_EN tie nack_cnt_o to 0 and instantiate no statistics register.

Structure
REQ-026 SHALL place the FREE/LOCKED state enum and a packed response struct (ack, id) in package trial_pkg.
REQ-027 SHALL implement the load/decrement/expire lease timer as sub-module lease_timer (parameters CntWidth, LeaseCycles).
REQ-028 SHALL provide elaboration-time checks for IdWidth >= 1 and the LeaseCycles bound, guarded by COMMON_CELLS_ASSERTS_OFF.

Verification
REQ-029 SHALL cover: reset, req id 3 -> next cycle rsp_ack_o=1, rsp_id_o=3, locked_o=1, owner_o=3.
REQ-030 SHALL cover: owner 3, req id 5 -> rsp_ack_o=0, rsp_id_o=5; with STATS_EN nack_cnt_o 0->1; without, 0.
REQ-031 SHALL cover: owner 3, same cycle rel id 3 and req id 5 -> ACK to 5, owner_o=5, timeout_o stays 0.
REQ-032 SHALL cover: LeaseCycles=4, grant to 2, no release -> timeout_o pulses one cycle, locked_o=0 after 4 LOCKED cycles.
REQ-033 SHALL cover: rsp_ready_i=0 for 3 cycles after a response -> rsp fields stable, req_ready_o=0, next req accepted on the rsp_ready_i=1 cycle.
REQ-034 SHALL cover: rel id 7 while owner 3, and reset asserted while LOCKED -> lock unchanged, then all outputs at reset values.
